// File: rtl/game_input_pkg.sv
// rtl/game_input_pkg.sv - shared command type, key channel indices and debounce constants
package game_input_pkg;

   typedef enum logic [1:0] {
      COMMAND_NONE  = 2'd0,
      COMMAND_HIT   = 2'd1,
      COMMAND_STAND = 2'd2
   } gameCommand;

   typedef enum logic {
      CMD_IDLE    = 1'b0,
      CMD_PENDING = 1'b1
   } cmd_state_t;

   localparam int KEY_HIT   = 0;
   localparam int KEY_STAND = 1;
   localparam int KEY_DEAL  = 2;

   localparam int DEBOUNCE_SIM  = 10;
   localparam int DEBOUNCE_PROD = 10000;

endpackage

// File: rtl/key_debounce_channel.sv
// rtl/key_debounce_channel.sv - one button: two-flop synchroniser, stable-count debounce, press/release pulses
module key_debounce_channel #(
   parameter int CNT_W           = 14,
   parameter int DEBOUNCE_CYCLES = 10
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_key,
   output logic o_level,
   output logic o_press,
   output logic o_release
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync_q1;
   logic             sync_q2;
   logic [CNT_W-1:0] count;
   logic             sample;

   // Buttons are active-low; the synchronisers idle at 1 so reset reads as released.
   assign sample = ~sync_q2;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         sync_q1   <= 1'b1;
         sync_q2   <= 1'b1;
         count     <= '0;
         o_level   <= 1'b0;
         o_press   <= 1'b0;
         o_release <= 1'b0;
      end else begin
         sync_q1   <= i_key;
         sync_q2   <= sync_q1;
         o_press   <= 1'b0;
         o_release <= 1'b0;
         if (sample == o_level) begin
            count <= '0;
         end else if (count == CNT_LAST) begin
            o_level   <= sample;
            count     <= '0;
            o_press   <= sample;
            o_release <= ~sample;
         end else begin
            count <= count + 1'b1;
         end
      end
   end

endmodule

// File: rtl/key_command_debouncer.sv
// rtl/key_command_debouncer.sv - debounced key front-end with HIT/STAND command handshake and DEAL pulse
module key_command_debouncer
   import game_input_pkg::*;
#(
   parameter int NUM_KEYS        = 3,
   parameter int CNT_W           = 14,
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_SIM
) (
   input  logic                i_clk,
   input  logic                i_rst_n,
   input  logic [NUM_KEYS-1:0] i_KEY,
   input  logic                i_turnIndicator,
   input  logic                i_cmd_ack,
   output logic [NUM_KEYS-1:0] o_key_level,
   output logic [NUM_KEYS-1:0] o_key_press,
   output logic [NUM_KEYS-1:0] o_key_release,
   output logic                o_dealButtonPushed,
   output logic                o_cmd_valid,
   output gameCommand          o_command,
   output logic                o_overrun
);

   cmd_state_t cmd_state;
   logic       qualify;
   gameCommand next_cmd;

   for (genvar k = 0; k < NUM_KEYS; k++) begin : g_chan
      key_debounce_channel #(
         .CNT_W           (CNT_W),
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
      ) u_chan (
         .i_clk     (i_clk),
         .i_rst_n   (i_rst_n),
         .i_key     (i_KEY[k]),
         .o_level   (o_key_level[k]),
         .o_press   (o_key_press[k]),
         .o_release (o_key_release[k])
      );
   end

   assign o_dealButtonPushed = o_key_press[KEY_DEAL];

   // STAND takes priority when both presses land on the same cycle.
   assign qualify  = o_key_press[KEY_HIT] | o_key_press[KEY_STAND];
   assign next_cmd = o_key_press[KEY_STAND] ? COMMAND_STAND : COMMAND_HIT;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         cmd_state   <= CMD_IDLE;
         o_cmd_valid <= 1'b0;
         o_command   <= COMMAND_NONE;
         o_overrun   <= 1'b0;
      end else begin
         o_overrun <= 1'b0;
         if (!i_turnIndicator) begin
            // Losing the turn cancels everything, including a same-cycle ack or press.
            cmd_state   <= CMD_IDLE;
            o_cmd_valid <= 1'b0;
            o_command   <= COMMAND_NONE;
         end else begin
            case (cmd_state)
               CMD_IDLE: begin
                  if (qualify) begin
                     cmd_state   <= CMD_PENDING;
                     o_cmd_valid <= 1'b1;
                     o_command   <= next_cmd;
                  end
               end
               CMD_PENDING: begin
                  if (i_cmd_ack) begin
                     if (qualify) begin
                        o_command <= next_cmd;
                     end else begin
                        cmd_state   <= CMD_IDLE;
                        o_cmd_valid <= 1'b0;
                        o_command   <= COMMAND_NONE;
                     end
                  end else if (qualify) begin
                     o_overrun <= 1'b1;
                  end
               end
               default: begin
                  cmd_state   <= CMD_IDLE;
                  o_cmd_valid <= 1'b0;
                  o_command   <= COMMAND_NONE;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_key_command_debouncer.sv
// tb/tb_key_command_debouncer.sv - directed and randomized bench against a window-based reference model
module tb_key_command_debouncer;
   import game_input_pkg::*;

   localparam int NK = 4;
   localparam int DC = 10;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [NK-1:0] key;
   logic          turn;
   logic          ack;
   logic [2:0]    key2;

   logic [NK-1:0] level, press, rel_w;
   logic          deal, valid, ovr;
   gameCommand    cmd;

   logic [2:0]    level2, press2, rel2;
   logic          deal2, valid2, ovr2;
   gameCommand    cmd2;

   always #5 clk = ~clk;

   key_command_debouncer #(.NUM_KEYS(NK), .CNT_W(14), .DEBOUNCE_CYCLES(DC)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_KEY(key), .i_turnIndicator(turn), .i_cmd_ack(ack),
      .o_key_level(level), .o_key_press(press), .o_key_release(rel_w),
      .o_dealButtonPushed(deal), .o_cmd_valid(valid), .o_command(cmd), .o_overrun(ovr)
   );

   key_command_debouncer #(.NUM_KEYS(3), .CNT_W(4), .DEBOUNCE_CYCLES(1)) dut_fast (
      .i_clk(clk), .i_rst_n(rst_n), .i_KEY(key2), .i_turnIndicator(turn), .i_cmd_ack(ack),
      .o_key_level(level2), .o_key_press(press2), .o_key_release(rel2),
      .o_dealButtonPushed(deal2), .o_cmd_valid(valid2), .o_command(cmd2), .o_overrun(ovr2)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference: a level flips once the last DC synchronised samples all disagree with it.
   logic [NK-1:0] kq[$];
   logic [NK-1:0] sq[$];
   logic [NK-1:0] m_level, m_press, m_rel;
   bit            m_pend, m_ovr;
   gameCommand    m_cmd;

   task automatic model_reset();
      kq.delete();
      kq.push_back('1);
      kq.push_back('1);
      sq.delete();
      m_level = '0;
      m_press = '0;
      m_rel   = '0;
      m_pend  = 1'b0;
      m_ovr   = 1'b0;
      m_cmd   = COMMAND_NONE;
   endtask

   task automatic model_edge();
      logic [NK-1:0] s, prev_press, e;
      bit            win, qual;
      gameCommand    nc;
      prev_press = m_press;
      kq.push_back(key);
      while (kq.size() > 3) void'(kq.pop_front());
      s = ~kq[0];
      sq.push_back(s);
      while (sq.size() > DC) void'(sq.pop_front());
      m_press = '0;
      m_rel   = '0;
      for (int c = 0; c < NK; c++) begin
         if (s[c] != m_level[c] && sq.size() == DC) begin
            win = 1'b1;
            for (int i = 0; i < DC; i++) begin
               e = sq[i];
               if (e[c] != s[c]) win = 1'b0;
            end
            if (win) begin
               m_level[c] = s[c];
               if (s[c]) m_press[c] = 1'b1;
               else      m_rel[c]   = 1'b1;
            end
         end
      end
      m_ovr = 1'b0;
      qual  = prev_press[0] | prev_press[1];
      nc    = prev_press[1] ? COMMAND_STAND : COMMAND_HIT;
      if (!turn) begin
         m_pend = 1'b0;
         m_cmd  = COMMAND_NONE;
      end else if (!m_pend) begin
         if (qual) begin
            m_pend = 1'b1;
            m_cmd  = nc;
         end
      end else if (ack) begin
         if (qual) m_cmd = nc;
         else begin
            m_pend = 1'b0;
            m_cmd  = COMMAND_NONE;
         end
      end else if (qual) begin
         m_ovr = 1'b1;
      end
   endtask

   task automatic compare();
      check("level",   32'(level),  32'(m_level));
      check("press",   32'(press),  32'(m_press));
      check("release", 32'(rel_w),  32'(m_rel));
      check("deal",    32'(deal),   32'(m_press[2]));
      check("valid",   32'(valid),  32'(m_pend));
      check("command", 32'(cmd),    32'(m_cmd));
      check("overrun", 32'(ovr),    32'(m_ovr));
   endtask

   task automatic step();
      @(posedge clk);
      if (!rst_n) model_reset();
      else        model_edge();
      #1;
      compare();
   endtask

   task automatic wait_press(input string tag, input int ch, input int exp_lat);
      int n;
      bit seen;
      n    = 0;
      seen = 1'b0;
      while (!seen && n < 60) begin
         step();
         n++;
         if (press[ch]) seen = 1'b1;
      end
      check(tag, seen ? 32'(n) : 32'd0, 32'(exp_lat));
   endtask

   initial begin
      int cnt, cnt2, n, r;
      bit seen;
      rst_n = 1'b0;
      key   = '0;
      key2  = '1;
      turn  = 1'b0;
      ack   = 1'b0;
      model_reset();

      // Reset state, then first press latency with key held through reset.
      repeat (3) step();
      key   = 4'b1110;
      rst_n = 1'b1;
      wait_press("reset_latency", 0, 12);
      cnt = 0;
      repeat (30) begin step(); if (press[0]) cnt++; end
      check("held_no_repeat", 32'(cnt), 32'd0);

      // Bounce rejection.
      key[0] = 1'b1;
      repeat (15) step();
      cnt = 0;
      for (int i = 0; i < 40; i++) begin
         if (i % 3 == 0) key[0] = ~key[0];
         step();
         if (press[0] || rel_w[0]) cnt++;
      end
      check("bounce_no_pulse", 32'(cnt), 32'd0);
      key[0] = 1'b0;
      wait_press("bounce_latency", 0, 12);
      check("bounce_level", 32'(level[0]), 32'd1);

      // HIT handshake.
      key[0] = 1'b1;
      repeat (15) step();
      turn = 1'b1;
      step();
      key[0] = 1'b0;
      wait_press("hit_latency", 0, 12);
      step();
      check("hit_valid", 32'(valid), 32'd1);
      check("hit_cmd", 32'(cmd), 32'(COMMAND_HIT));
      repeat (20) step();
      check("hit_held", 32'(cmd), 32'(COMMAND_HIT));
      ack = 1'b1;
      step();
      ack = 1'b0;
      check("hit_acked", 32'(valid), 32'd0);
      key = '1;
      repeat (15) step();

      // Simultaneous press then overrun.
      key[1:0] = 2'b00;
      wait_press("simul_latency", 1, 12);
      step();
      check("simul_stand", 32'(cmd), 32'(COMMAND_STAND));
      key[0] = 1'b1;
      repeat (15) step();
      key[0] = 1'b0;
      cnt = 0;
      repeat (20) begin step(); if (ovr) cnt++; end
      check("overrun_once", 32'(cnt), 32'd1);
      check("overrun_cmd", 32'(cmd), 32'(COMMAND_STAND));
      ack = 1'b1;
      step();
      ack = 1'b0;
      key = '1;
      repeat (15) step();

      // Turn gating and cancel.
      turn   = 1'b0;
      key[1] = 1'b0;
      cnt = 0;
      repeat (20) begin step(); if (valid || ovr) cnt++; end
      check("gated_ignored", 32'(cnt), 32'd0);
      key  = '1;
      repeat (15) step();
      turn = 1'b1;
      key[0] = 1'b0;
      wait_press("cancel_first", 0, 12);
      step();
      check("cancel_pending", 32'(valid), 32'd1);
      key[0] = 1'b1;
      repeat (15) step();
      key[0] = 1'b0;
      wait_press("cancel_second", 0, 12);
      turn = 1'b0;
      ack  = 1'b1;
      step();
      ack  = 1'b0;
      check("cancel_valid", 32'(valid), 32'd0);
      check("cancel_ovr", 32'(ovr), 32'd0);
      key = '1;
      repeat (15) step();

      // DEAL and the extra channel.
      key[2] = 1'b0;
      cnt = 0;
      repeat (20) begin step(); if (deal) cnt++; end
      check("deal_once", 32'(cnt), 32'd1);
      key[2] = 1'b1;
      repeat (15) step();
      turn   = 1'b1;
      key[3] = 1'b0;
      cnt = 0;
      cnt2 = 0;
      repeat (20) begin step(); if (press[3]) cnt++; if (valid) cnt2++; end
      check("extra_press", 32'(cnt), 32'd1);
      check("extra_no_cmd", 32'(cnt2), 32'd0);
      key[3] = 1'b1;
      repeat (15) step();

      // Asynchronous reset while a command is pending.
      key[0] = 1'b0;
      wait_press("pend_before_reset", 0, 12);
      step();
      rst_n = 1'b0;
      #1;
      check("rst_valid", 32'(valid), 32'd0);
      check("rst_cmd", 32'(cmd), 32'(COMMAND_NONE));
      check("rst_level", 32'(level), 32'd0);
      step();
      key   = '1;
      rst_n = 1'b1;
      repeat (15) step();

      // Minimum debounce depth on the second instance.
      key2[0] = 1'b0;
      n = 0;
      seen = 1'b0;
      while (!seen && n < 20) begin
         step();
         n++;
         if (press2[0]) seen = 1'b1;
      end
      check("fast_latency", seen ? 32'(n) : 32'd0, 32'd3);

      // Randomized traffic across all channels.
      r = 8;
      for (int i = 0; i < 3000; i++) begin
         if (i % 200 == 0) r = int'($urandom_range(40, 2));
         for (int c = 0; c < NK; c++)
            if ($urandom_range(r - 1, 0) == 0) key[c] = ~key[c];
         if ($urandom_range(63, 0) == 0) turn = ~turn;
         ack = ($urandom_range(3, 0) == 0);
         step();
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
